mul_sched: RTL and testbench

Command scheduler that sequences the systolic multiplier (mem_mode/calc_init/memory-controller path) as a queued job engine. Requesters push jobs (mode + tag) into a small FIFO; the scheduler launches each job, holds mem_mode stable while it runs, waits for completion or a timeout, and returns a tagged response. It sits between the top-level control/host logic and the multiplier top, and is the only driver of mem_mode and calc_init.

---
 rtl/mul_sched.sv | 162 ++++++++++++++++
 tb/tb_mul_sched.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sched.sv
// Job scheduler for the systolic multiplier: queues {mode, tag} commands, launches
// each job with a one-cycle calc_init, supervises completion/abort/timeout and returns a tagged response.
module mul_sched #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [2:0]       mem_mode,
  output logic             calc_init,
  input  logic             mul_done,
  input  logic             abort,
  output logic             busy,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [15:0]      jobs_done
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  logic [2:0]       mode_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem  [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2:0]       state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             err_q, err_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [15:0]      jobs_q, jobs_d;

  logic             push;
  logic             pop;
  logic [2:0]       head_mode;
  logic [TAG_W-1:0] head_tag;
  logic             head_legal;

  assign head_mode  = mode_mem[rd_ptr_q];
  assign head_tag   = tag_mem[rd_ptr_q];
  assign head_legal = (head_mode != 3'd0) && (head_mode <= 3'd4);

  assign cmd_ready = (count_q < CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);

  // Every output is decoded from registered state only.
  assign mem_mode  = ((state_q == S_LAUNCH) || (state_q == S_RUN)) ? mode_q : 3'd0;
  assign calc_init = (state_q == S_LAUNCH);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_tag   = tag_q;
  assign rsp_err   = err_q;
  assign jobs_done = jobs_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mode_mem[wr_ptr_q] <= cmd_mode;
      tag_mem[wr_ptr_q]  <= cmd_tag;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    jobs_d  = jobs_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          tag_d = head_tag;
          if (head_legal) begin
            mode_d  = head_mode;
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_LAUNCH;
          end else begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = cnt_q + TW'(1);
        state_d = S_RUN;
      end
      S_RUN: begin
        // cnt_q counts cycles since LAUNCH, so RESP lands exactly TIMEOUT cycles after it.
        cnt_d = cnt_q + TW'(1);
        if (mul_done) begin
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (abort || (cnt_q == TW'(TIMEOUT - 1))) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          jobs_d  = jobs_q + 16'd1;
          state_d = S_GAP;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      mode_q   <= '0;
      tag_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      jobs_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      mode_q   <= mode_d;
      tag_q    <= tag_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      jobs_q   <= jobs_d;
    end
  end

endmodule

// File: tb/tb_mul_sched.sv
// Self-checking bench for mul_sched: directed vector table, fill/order, reset-mid-job
// and a randomized producer/consumer run checked against a job-level reference model.
module tb_mul_sched;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_mode;
  logic [TAG_W-1:0] cmd_tag;
  logic [2:0]       mem_mode;
  logic             calc_init;
  logic             mul_done;
  logic             abort;
  logic             busy;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic [15:0]      jobs_done;

  mul_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_tag(cmd_tag),
    .mem_mode(mem_mode), .calc_init(calc_init), .mul_done(mul_done), .abort(abort),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .rsp_err(rsp_err), .jobs_done(jobs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = mul_done after dly, 1 = abort after dly, 2 = both together, 3 = no event (timeout)
  typedef struct {
    logic [2:0] mode;
    logic [3:0] tag;
    int         kind;
    int         dly;
    int         bp;
    bit         err;
  } job_t;

  int   nvec = 0;
  int   nmis = 0;
  int   last_launch = -100;
  int   jd_exp = 0;
  job_t sbq[$];

  function automatic void chk(string name, int act, int want);
    nvec++;
    if (act != want) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  function automatic bit legal(logic [2:0] m);
    return (m >= 3'd1) && (m <= 3'd4);
  endfunction

  // Reference rule: error for illegal mode, for abort alone, or for timeout; done always wins.
  function automatic bit model_err(job_t j);
    return !legal(j.mode) || (j.kind == 1) || (j.kind == 3);
  endfunction

  task automatic check_reset();
    chk("rst_mem_mode", mem_mode, 0);
    chk("rst_calc_init", calc_init, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_jobs_done", jobs_done, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
  endtask

  task automatic push(job_t j, bit to_sb);
    int g = 0;
    cmd_valid = 1'b1;
    cmd_mode  = j.mode;
    cmd_tag   = j.tag;
    while (!cmd_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("push_accept", cmd_ready, 1);
    if (to_sb && cmd_ready) sbq.push_back(j);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Plays the multiplier and response consumer for one job; called on a negedge.
  task automatic serve(job_t j);
    int g;
    logic [3:0] t0;
    logic e0;
    if (legal(j.mode)) begin
      g = 0;
      while (!calc_init && g < 64) begin
        @(negedge clk);
        g++;
      end
      chk("launch_seen", calc_init, 1);
      if (!calc_init) return;
      chk("launch_mode", mem_mode, j.mode);
      chk("launch_spacing", int'((cyc - last_launch) >= 4), 1);
      last_launch = cyc;
      if (j.kind == 3) begin
        for (int i = 1; i < int'(TIMEOUT); i++) begin
          @(negedge clk);
          chk("run_no_rsp", rsp_valid, 0);
          chk("run_mode_held", mem_mode, j.mode);
          chk("run_no_init", calc_init, 0);
        end
        @(negedge clk);
      end else begin
        for (int i = 1; i <= j.dly; i++) begin
          @(negedge clk);
          chk("run_no_rsp", rsp_valid, 0);
          chk("run_mode_held", mem_mode, j.mode);
          chk("run_no_init", calc_init, 0);
        end
        mul_done = (j.kind != 1);
        abort    = (j.kind != 0);
        @(negedge clk);
        mul_done = 1'b0;
        abort    = 1'b0;
      end
    end else begin
      g = 0;
      while (!rsp_valid && g < 64) begin
        chk("illegal_no_init", calc_init, 0);
        @(negedge clk);
        g++;
      end
    end
    chk("rsp_valid", rsp_valid, 1);
    if (!rsp_valid) return;
    chk("rsp_tag", rsp_tag, j.tag);
    chk("rsp_err", rsp_err, j.err);
    chk("resp_mode_zero", mem_mode, 0);
    chk("resp_no_init", calc_init, 0);
    chk("resp_busy", busy, 1);
    t0 = rsp_tag;
    e0 = rsp_err;
    for (int i = 0; i < j.bp; i++) begin
      mul_done = (i % 2 == 0);
      abort    = (i % 2 == 1);
      @(negedge clk);
      chk("bp_valid_held", rsp_valid, 1);
      chk("bp_tag_stable", rsp_tag, t0);
      chk("bp_err_stable", rsp_err, e0);
      chk("bp_no_init", calc_init, 0);
    end
    mul_done  = 1'b0;
    abort     = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    jd_exp = (jd_exp + 1) & 16'hffff;
    chk("jobs_done", jobs_done, jd_exp);
    chk("gap_rsp_low", rsp_valid, 0);
    chk("gap_mode_zero", mem_mode, 0);
    chk("gap_busy", busy, 1);
  endtask

  job_t tbl[11];
  job_t fj[6];
  job_t rj[4];
  localparam int NRAND = 30;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_tag = '0;
    mul_done = 1'b0; abort = 1'b0; rsp_ready = 1'b0;

    //             mode  tag  kind dly bp  err
    tbl[0]  = '{3'd1, 4'd3,  0, 10, 0,  1'b0};
    tbl[1]  = '{3'd0, 4'd5,  0,  1, 0,  1'b1};
    tbl[2]  = '{3'd2, 4'd6,  3,  0, 0,  1'b1};
    tbl[3]  = '{3'd3, 4'd9,  2,  4, 0,  1'b0};
    tbl[4]  = '{3'd4, 4'd10, 1,  7, 0,  1'b1};
    tbl[5]  = '{3'd1, 4'd12, 0,  3, 20, 1'b0};
    tbl[6]  = '{3'd7, 4'd15, 0,  1, 5,  1'b1};
    tbl[7]  = '{3'd5, 4'd1,  0,  1, 0,  1'b1};
    tbl[8]  = '{3'd2, 4'd14, 0, 15, 0,  1'b0};
    tbl[9]  = '{3'd3, 4'd2,  1, 15, 2,  1'b1};
    tbl[10] = '{3'd4, 4'd0,  0,  1, 0,  1'b0};

    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;
    @(negedge clk);
    check_reset();

    for (int i = 0; i < 11; i++) begin
      push(tbl[i], 1'b0);
      chk("idle_after_push", busy, 0);
      chk("no_early_init", calc_init, 0);
      @(negedge clk);
      if (legal(tbl[i].mode)) chk("launch_latency", calc_init, 1);
      else begin
        chk("illegal_latency", rsp_valid, 1);
        chk("illegal_no_init", calc_init, 0);
      end
      serve(tbl[i]);
      @(negedge clk);
      chk("back_to_idle", busy, 0);
    end

    // Fill and order: tags 0..5 while job 0 runs; the queue saturates after four entries.
    for (int i = 0; i < 6; i++) fj[i] = '{3'((i % 4) + 1), 4'(i), 0, 10, 0, 1'b0};
    fork
      begin
        for (int i = 0; i < 5; i++) push(fj[i], 1'b0);
        chk("fifo_full_ready", cmd_ready, 0);
        push(fj[5], 1'b0);
      end
      begin
        for (int i = 0; i < 6; i++) serve(fj[i]);
      end
    join
    @(negedge clk);

    // Randomized run: producer feeds a scoreboard queue, consumer serves in FIFO order.
    fork
      begin
        for (int i = 0; i < NRAND; i++) begin
          job_t j;
          int k;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          j.mode = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
          j.tag  = 4'($urandom);
          k      = int'($urandom_range(0, 9));
          j.kind = (k < 6) ? 0 : (k < 8) ? 1 : (k == 8) ? 2 : 3;
          j.dly  = int'($urandom_range(1, 15));
          j.bp   = int'($urandom_range(0, 3));
          j.err  = model_err(j);
          push(j, 1'b1);
        end
      end
      begin
        for (int i = 0; i < NRAND; i++) begin
          int g = 0;
          job_t j;
          while (sbq.size() == 0 && g < 400) begin
            @(negedge clk);
            g++;
          end
          chk("sb_job_available", int'(sbq.size() != 0), 1);
          if (sbq.size() != 0) begin
            j = sbq.pop_front();
            serve(j);
          end
        end
      end
    join
    @(negedge clk);

    // Reset while a job runs with three more queued.
    for (int i = 0; i < 4; i++) rj[i] = '{3'd3, 4'(7 + i), 0, 5, 0, 1'b0};
    push(rj[0], 1'b0);
    @(negedge clk);
    chk("pre_reset_launch", calc_init, 1);
    for (int i = 1; i < 4; i++) push(rj[i], 1'b0);
    chk("pre_reset_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    jd_exp = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("post_rst_no_init", calc_init, 0);
      chk("post_rst_no_rsp", rsp_valid, 0);
      chk("post_rst_idle", busy, 0);
    end
    push('{3'd2, 4'd11, 0, 6, 1, 1'b0}, 1'b0);
    serve('{3'd2, 4'd11, 0, 6, 1, 1'b0});
    chk("post_rst_jobs_done", jobs_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
